// File: rtl/key_cmd_scheduler.sv
// key_cmd_scheduler
// Turns single-cycle key-press pulses into a FIFO of command codes and issues
// them to game logic through a valid/ready handshake, with an enforced idle
// gap between consecutive issued commands.
//
// Ports
//   clk         system clock, all logic on posedge
//   rst         synchronous active-high reset
//   ev_enter, ev_space, ev_w, ev_a, ev_d
//               key-press pulses (priority enter > space > W > A > D)
//   flush       synchronous clear of all queued commands
//   cmd_valid   head command presented to game logic
//   cmd_code    1 enter, 2 space, 3 W, 4 A, 5 D; 0 while cmd_valid is low
//   cmd_ready   game logic accepts the presented command
//   fifo_count  queued entries, including the one being presented
//   overflow    sticky: at least one key event was lost (cleared by rst only)
module key_cmd_scheduler #(
   parameter int DEPTH      = 4,
   parameter int GAP_CYCLES = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     ev_enter,
   input  logic                     ev_space,
   input  logic                     ev_w,
   input  logic                     ev_a,
   input  logic                     ev_d,
   input  logic                     flush,
   output logic                     cmd_valid,
   output logic [2:0]               cmd_code,
   input  logic                     cmd_ready,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic                     overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int GW = (GAP_CYCLES < 1) ? 1 : $clog2(GAP_CYCLES + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;

   state_t          state_reg;
   logic [AW-1:0]   wr_ptr_reg;
   logic [AW-1:0]   rd_ptr_reg;
   logic [CW-1:0]   count_reg;
   logic [GW-1:0]   gap_cnt_reg;
   logic            cmd_valid_reg;
   logic [2:0]      cmd_code_reg;
   logic            overflow_reg;
   logic [2:0]      mem [DEPTH];

   // Event vector, bit 0 is the highest priority.
   logic [4:0]      ev_vec;
   logic [4:0]      shadowed;
   logic            ev_any;
   logic            ev_lost;
   logic [2:0]      ev_code;

   logic            full;
   logic            pop;
   logic            push_ok;
   logic            push_drop;
   logic [AW-1:0]   rd_ptr_inc;

   assign ev_vec = {ev_d, ev_a, ev_w, ev_space, ev_enter};

   // A pulse is shadowed when any higher-priority pulse is asserted with it.
   genvar gi;
   generate
      for (gi = 0; gi < 5; gi++) begin : g_shadow
         if (gi == 0) begin : g_top
            assign shadowed[gi] = 1'b0;
         end else begin : g_low
            assign shadowed[gi] = ev_vec[gi] & (|ev_vec[gi-1:0]);
         end
      end
   endgenerate

   assign ev_any  = |ev_vec;
   assign ev_lost = |shadowed;

   always_comb begin
      ev_code = 3'd0;
      if (ev_enter)      ev_code = 3'd1;
      else if (ev_space) ev_code = 3'd2;
      else if (ev_w)     ev_code = 3'd3;
      else if (ev_a)     ev_code = 3'd4;
      else if (ev_d)     ev_code = 3'd5;
   end

   // cmd_valid_reg is high exactly while in ISSUE, so the handshake is keyed
   // on the state; flush withdraws the command and suppresses the pop.
   assign full       = (count_reg == CW'(DEPTH));
   assign pop        = (state_reg == ISSUE) && cmd_ready && !flush;
   assign push_ok    = ev_any && !flush && (!full || pop);
   assign push_drop  = ev_any && !flush && full && !pop;
   assign rd_ptr_inc = rd_ptr_reg + 1'b1;

   // Storage carries no reset; validity is tracked by the pointers and count.
   always_ff @(posedge clk) begin
      if (!rst && push_ok) begin
         mem[wr_ptr_reg] <= ev_code;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= IDLE;
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
         count_reg     <= '0;
         gap_cnt_reg   <= '0;
         cmd_valid_reg <= 1'b0;
         cmd_code_reg  <= 3'd0;
         overflow_reg  <= 1'b0;
      end else if (flush) begin
         state_reg     <= IDLE;
         wr_ptr_reg    <= '0;
         rd_ptr_reg    <= '0;
         count_reg     <= '0;
         gap_cnt_reg   <= '0;
         cmd_valid_reg <= 1'b0;
         cmd_code_reg  <= 3'd0;
      end else begin
         if (push_ok) wr_ptr_reg <= wr_ptr_reg + 1'b1;
         if (pop)     rd_ptr_reg <= rd_ptr_inc;
         case ({push_ok, pop})
            2'b10:   count_reg <= count_reg + 1'b1;
            2'b01:   count_reg <= count_reg - 1'b1;
            default: count_reg <= count_reg;
         endcase
         if (ev_lost || push_drop) overflow_reg <= 1'b1;

         case (state_reg)
            IDLE: begin
               if (count_reg != '0) begin
                  state_reg     <= ISSUE;
                  cmd_valid_reg <= 1'b1;
                  cmd_code_reg  <= mem[rd_ptr_reg];
               end
            end
            ISSUE: begin
               if (cmd_ready) begin
                  if (GAP_CYCLES > 0) begin
                     state_reg     <= GAP;
                     gap_cnt_reg   <= GW'(GAP_CYCLES);
                     cmd_valid_reg <= 1'b0;
                     cmd_code_reg  <= 3'd0;
                  end else if (count_reg > CW'(1)) begin
                     // Back-to-back issue: present the entry behind the head.
                     cmd_code_reg  <= mem[rd_ptr_inc];
                  end else begin
                     state_reg     <= IDLE;
                     cmd_valid_reg <= 1'b0;
                     cmd_code_reg  <= 3'd0;
                  end
               end
            end
            GAP: begin
               // Counter holds GAP_CYCLES on the first gap cycle; leaving at
               // value 1 gives exactly GAP_CYCLES idle cycles.
               if (gap_cnt_reg <= GW'(1)) begin
                  gap_cnt_reg <= '0;
                  if (count_reg != '0) begin
                     state_reg     <= ISSUE;
                     cmd_valid_reg <= 1'b1;
                     cmd_code_reg  <= mem[rd_ptr_reg];
                  end else begin
                     state_reg     <= IDLE;
                  end
               end else begin
                  gap_cnt_reg <= gap_cnt_reg - 1'b1;
               end
            end
            default: begin
               state_reg     <= IDLE;
               cmd_valid_reg <= 1'b0;
               cmd_code_reg  <= 3'd0;
            end
         endcase
      end
   end

   assign cmd_valid  = cmd_valid_reg;
   assign cmd_code   = cmd_code_reg;
   assign fifo_count = count_reg;
   assign overflow   = overflow_reg;

endmodule

// File: tb/tb_key_cmd_scheduler.sv
// Bench for key_cmd_scheduler: a cycle monitor keeps a queue model of the
// command FIFO and the overflow flag, checking outputs every cycle and codes
// at each handshake; a table of single-cycle vectors plus hand-written
// sequences cover latency, priority drop, full FIFO, flush and reset.
module tb_key_cmd_scheduler;

   localparam int DEPTH = 4;
   localparam int GAP   = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic       ev_enter, ev_space, ev_w, ev_a, ev_d;
   logic       flush;
   logic       cmd_ready;
   logic       cmd_valid;
   logic [2:0] cmd_code;
   logic [2:0] fifo_count;
   logic       overflow;

   always #5 clk = ~clk;

   key_cmd_scheduler #(.DEPTH(DEPTH), .GAP_CYCLES(GAP)) dut (
      .clk        (clk),
      .rst        (rst),
      .ev_enter   (ev_enter),
      .ev_space   (ev_space),
      .ev_w       (ev_w),
      .ev_a       (ev_a),
      .ev_d       (ev_d),
      .flush      (flush),
      .cmd_valid  (cmd_valid),
      .cmd_code   (cmd_code),
      .cmd_ready  (cmd_ready),
      .fifo_count (fifo_count),
      .overflow   (overflow)
   );

   int         n_vec = 0;
   int         n_err = 0;
   int         cyc   = 0;
   bit         chk   = 0;
   logic [2:0] exp_q [$];
   logic       m_ovf = 1'b0;
   int         hs_cyc [$];

   // Event vector bit order: {d, a, w, space, enter}
   localparam logic [4:0] E_ENT = 5'b00001;
   localparam logic [4:0] E_SPC = 5'b00010;
   localparam logic [4:0] E_W   = 5'b00100;
   localparam logic [4:0] E_A   = 5'b01000;
   localparam logic [4:0] E_D   = 5'b10000;

   typedef struct {
      logic [4:0] ev;
      logic       fl;
      int         cnt;
      logic       ovf;
   } vec_t;

   vec_t tbl [9];

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [2:0] enc(input logic [4:0] e);
      if (e[0]) return 3'd1;
      if (e[1]) return 3'd2;
      if (e[2]) return 3'd3;
      if (e[3]) return 3'd4;
      if (e[4]) return 3'd5;
      return 3'd0;
   endfunction

   // Runs at the falling edge: compare outputs against the model, then
   // advance the model by what the coming rising edge will do.
   task automatic monitor();
      logic [4:0] e;
      bit         pop;
      bit         was_full;
      cyc++;
      if (chk) begin
         check("fifo_count", fifo_count, exp_q.size());
         check("overflow", overflow, m_ovf);
         if (!cmd_valid) check("cmd_code_idle", cmd_code, 0);
      end
      if (rst) begin
         exp_q.delete();
         m_ovf = 1'b0;
      end else if (flush) begin
         exp_q.delete();
      end else begin
         e        = {ev_d, ev_a, ev_w, ev_space, ev_enter};
         pop      = cmd_valid && cmd_ready;
         was_full = (exp_q.size() == DEPTH);
         if (pop) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_err++;
               $display("FAIL handshake_unexpected: got code %0d, expected none (cycle %0d)", cmd_code, cyc);
            end else begin
               $display("handshake cycle %0d code %0d", cyc, cmd_code);
               check("cmd_code", cmd_code, exp_q.pop_front());
               hs_cyc.push_back(cyc);
            end
         end
         if (e != 5'b0) begin
            if (!was_full || pop) exp_q.push_back(enc(e));
            else m_ovf = 1'b1;
            if ($countones(e) > 1) m_ovf = 1'b1;
         end
      end
   endtask

   task automatic step();
      @(negedge clk);
      monitor();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ev(input logic [4:0] e);
      {ev_d, ev_a, ev_w, ev_space, ev_enter} = e;
   endtask

   task automatic pulse(input logic [4:0] e);
      set_ev(e);
      step();
      set_ev(5'b0);
   endtask

   task automatic do_reset();
      rst   = 1'b1;
      flush = 1'b0;
      set_ev(5'b0);
      step();
      rst = 1'b0;
   endtask

   task automatic wait_valid(input int max_cyc);
      int n = 0;
      while (!cmd_valid && n < max_cyc) begin
         step();
         n++;
      end
      if (!cmd_valid) begin
         n_vec++;
         n_err++;
         $display("FAIL wait_valid: cmd_valid still 0 after %0d cycles, expected 1", max_cyc);
      end
   endtask

   initial begin
      rst       = 1'b1;
      flush     = 1'b0;
      cmd_ready = 1'b0;
      set_ev(5'b0);
      step();
      chk = 1;
      step();
      check("rst_valid", cmd_valid, 0);
      check("rst_code", cmd_code, 0);
      check("rst_count", fifo_count, 0);
      check("rst_ovf", overflow, 0);
      rst = 1'b0;

      // Single W pulse, ready tied high: issue at N+2 for one cycle.
      cmd_ready = 1'b1;
      repeat (3) step();
      pulse(E_W);
      check("a_valid_n1", cmd_valid, 0);
      check("a_count_n1", fifo_count, 1);
      step();
      check("a_valid_n2", cmd_valid, 1);
      check("a_code_n2", cmd_code, 3);
      step();
      check("a_valid_n3", cmd_valid, 0);
      check("a_count_n3", fifo_count, 0);
      repeat (GAP + 2) step();

      // enter and D together: only enter queued, overflow set.
      do_reset();
      cmd_ready = 1'b0;
      pulse(E_ENT | E_D);
      check("b_count", fifo_count, 1);
      check("b_ovf", overflow, 1);
      step();
      check("b_valid", cmd_valid, 1);
      check("b_code", cmd_code, 1);
      flush = 1'b1;
      step();
      flush = 1'b0;
      check("b_flush_count", fifo_count, 0);
      check("b_flush_ovf", overflow, 1);

      // Table of single-cycle vectors with cmd_ready low.
      tbl[0] = '{5'b0,           1'b0, 0, 1'b0};
      tbl[1] = '{E_W,            1'b0, 1, 1'b0};
      tbl[2] = '{E_A,            1'b0, 2, 1'b0};
      tbl[3] = '{E_D,            1'b0, 3, 1'b0};
      tbl[4] = '{E_SPC,          1'b0, 4, 1'b0};
      tbl[5] = '{E_ENT,          1'b0, 4, 1'b1};
      tbl[6] = '{E_W,            1'b1, 0, 1'b1};
      tbl[7] = '{E_SPC,          1'b0, 1, 1'b1};
      tbl[8] = '{E_ENT|E_SPC|E_W, 1'b0, 2, 1'b1};
      do_reset();
      for (int i = 0; i < 9; i++) begin
         set_ev(tbl[i].ev);
         flush = tbl[i].fl;
         step();
         set_ev(5'b0);
         flush = 1'b0;
         check($sformatf("tbl%0d_count", i), fifo_count, tbl[i].cnt);
         check($sformatf("tbl%0d_ovf", i), overflow, tbl[i].ovf);
      end
      cmd_ready = 1'b1;
      repeat (3 * (GAP + 1) + 2) step();
      check("tbl_drain_count", fifo_count, 0);

      // Six pulses into a 4-deep FIFO, then push + handshake while full.
      do_reset();
      cmd_ready = 1'b0;
      pulse(E_W);
      pulse(E_A);
      pulse(E_D);
      pulse(E_SPC);
      pulse(E_ENT);
      pulse(E_W);
      check("c_count_full", fifo_count, 4);
      check("c_ovf", overflow, 1);
      check("c_valid", cmd_valid, 1);
      check("c_head", cmd_code, 3);
      hs_cyc.delete();
      cmd_ready = 1'b1;
      pulse(E_A);
      check("c_pushpop_count", fifo_count, 4);
      check("c_pushpop_ovf", overflow, 1);
      repeat (5 * (GAP + 1) + 4) step();
      check("c_hs_total", hs_cyc.size(), 5);
      for (int i = 1; i < hs_cyc.size(); i++)
         check($sformatf("c_spacing%0d", i), hs_cyc[i] - hs_cyc[i-1], GAP + 1);
      check("c_drain_count", fifo_count, 0);

      // Flush during ISSUE with cmd_ready high withdraws the command.
      do_reset();
      cmd_ready = 1'b0;
      pulse(E_W);
      pulse(E_A);
      wait_valid(5);
      cmd_ready = 1'b1;
      flush     = 1'b1;
      step();
      flush = 1'b0;
      check("d_valid", cmd_valid, 0);
      check("d_count", fifo_count, 0);
      check("d_ovf", overflow, 0);
      step();
      check("d_idle_valid", cmd_valid, 0);

      // Reset while in GAP with entries queued.
      do_reset();
      cmd_ready = 1'b1;
      pulse(E_W);
      pulse(E_A);
      pulse(E_D);
      check("e_gap_valid", cmd_valid, 0);
      check("e_gap_count", fifo_count, 2);
      rst = 1'b1;
      set_ev(E_W);
      step();
      rst = 1'b0;
      set_ev(5'b0);
      check("e_rst_valid", cmd_valid, 0);
      check("e_rst_code", cmd_code, 0);
      check("e_rst_count", fifo_count, 0);
      check("e_rst_ovf", overflow, 0);
      pulse(E_D);
      check("e_valid_n1", cmd_valid, 0);
      step();
      check("e_valid_n2", cmd_valid, 1);
      check("e_code_n2", cmd_code, 5);
      repeat (GAP + 3) step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
